// File: rtl/multi_dir_sequencer.sv
//------------------------------------------------------------------------------
// Module   : multi_dir_sequencer
// Brief    : Round-robin FORWARD/RIGHT/LEFT/OFF light sequencer for N_DIR
//            approaches with shadow-buffered, cycle-boundary phase durations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_dir_sequencer #(
  parameter int N_DIR   = 2,
  parameter int CNT_W   = 8,
  parameter int T_FWD   = 15,
  parameter int T_RIGHT = 10,
  parameter int T_LEFT  = 10,
  parameter int T_OFF   = 3,
  localparam int DIR_W  = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               hold,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_phase,
  input  logic [CNT_W-1:0]   cfg_data,
  output logic [2*N_DIR-1:0] light,
  output logic [CNT_W-1:0]   countdown,
  output logic [DIR_W-1:0]   active_dir,
  output logic               cycle_done
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_fwd  = 3'd1;
  localparam logic [2:0] c_st_rgt  = 3'd2;
  localparam logic [2:0] c_st_lft  = 3'd3;
  localparam logic [2:0] c_st_clr  = 3'd4;

  // Phase codes double as indices into the duration register sets.
  localparam logic [1:0] c_ph_off   = 2'b00;
  localparam logic [1:0] c_ph_left  = 2'b01;
  localparam logic [1:0] c_ph_fwd   = 2'b10;
  localparam logic [1:0] c_ph_right = 2'b11;

  logic [2:0]         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [DIR_W-1:0]   r_dir, w_dir_nxt;
  logic [2*N_DIR-1:0] r_light, w_light_nxt;
  logic               r_cycle_done;
  logic [CNT_W-1:0]   r_shadow [4];
  logic [CNT_W-1:0]   r_active [4];
  logic [CNT_W-1:0]   w_shadow_nxt [4];
  logic [CNT_W-1:0]   w_wr_data;
  logic [CNT_W-1:0]   w_count_dec;
  logic [1:0]         w_code;
  logic               w_expire, w_last, w_wrap, w_copy;

  assign w_wr_data   = (cfg_data == '0) ? CNT_W'(1) : cfg_data;
  assign w_count_dec = r_count - CNT_W'(1);
  assign w_expire    = (r_count == CNT_W'(1));
  assign w_last      = (r_dir == DIR_W'(N_DIR - 1));
  assign w_wrap      = enable && !hold && (r_state == c_st_clr) && w_expire && w_last;
  // A held IDLE does not copy; a disabled IDLE does, so the exit load is always fresh.
  assign w_copy      = ((r_state == c_st_idle) && !(enable && hold)) || w_wrap;

  // Shadow view including this cycle's write, so a coincident copy picks it up.
  always_comb begin
    for (int i = 0; i < 4; i++) w_shadow_nxt[i] = r_shadow[i];
    if (cfg_we) w_shadow_nxt[cfg_phase] = w_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow[c_ph_off]   <= CNT_W'(T_OFF);
      r_shadow[c_ph_left]  <= CNT_W'(T_LEFT);
      r_shadow[c_ph_fwd]   <= CNT_W'(T_FWD);
      r_shadow[c_ph_right] <= CNT_W'(T_RIGHT);
      r_active[c_ph_off]   <= CNT_W'(T_OFF);
      r_active[c_ph_left]  <= CNT_W'(T_LEFT);
      r_active[c_ph_fwd]   <= CNT_W'(T_FWD);
      r_active[c_ph_right] <= CNT_W'(T_RIGHT);
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (w_copy) r_active[i] <= w_shadow_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_st_idle;
      r_count      <= '0;
      r_dir        <= '0;
      r_light      <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_dir        <= w_dir_nxt;
      r_light      <= w_light_nxt;
      r_cycle_done <= w_wrap;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    if (!enable) begin
      w_state_nxt = c_st_idle;
      w_count_nxt = '0;
      w_dir_nxt   = '0;
    end else if (!hold) begin
      case (r_state)
        c_st_idle: begin
          w_state_nxt = c_st_fwd;
          w_count_nxt = w_shadow_nxt[c_ph_fwd];
          w_dir_nxt   = '0;
        end
        c_st_fwd: begin
          w_state_nxt = w_expire ? c_st_rgt : c_st_fwd;
          w_count_nxt = w_expire ? r_active[c_ph_right] : w_count_dec;
        end
        c_st_rgt: begin
          w_state_nxt = w_expire ? c_st_lft : c_st_rgt;
          w_count_nxt = w_expire ? r_active[c_ph_left] : w_count_dec;
        end
        c_st_lft: begin
          w_state_nxt = w_expire ? c_st_clr : c_st_lft;
          w_count_nxt = w_expire ? r_active[c_ph_off] : w_count_dec;
        end
        c_st_clr: begin
          if (w_expire) begin
            w_state_nxt = c_st_fwd;
            w_dir_nxt   = w_last ? '0 : r_dir + DIR_W'(1);
            w_count_nxt = w_last ? w_shadow_nxt[c_ph_fwd] : r_active[c_ph_fwd];
          end else begin
            w_count_nxt = w_count_dec;
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_count_nxt = '0;
          w_dir_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    case (w_state_nxt)
      c_st_fwd: w_code = c_ph_fwd;
      c_st_rgt: w_code = c_ph_right;
      c_st_lft: w_code = c_ph_left;
      default:  w_code = c_ph_off;
    endcase
    w_light_nxt = '0;
    for (int k = 0; k < N_DIR; k++) begin
      if (w_dir_nxt == DIR_W'(k)) w_light_nxt[2*k +: 2] = w_code;
    end
  end

  assign light      = r_light;
  assign countdown  = r_count;
  assign active_dir = r_dir;
  assign cycle_done = r_cycle_done;

endmodule

`default_nettype wire

// File: tb/tb_multi_dir_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_multi_dir_sequencer
// Brief    : Directed self-checking bench for multi_dir_sequencer (N_DIR=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_dir_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, enable, hold, cfg_we;
  logic [1:0] cfg_phase;
  logic [7:0] cfg_data;
  logic [3:0] light;
  logic [7:0] countdown;
  logic [0:0] active_dir;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cyc;
    int l;
    int c;
    int d;
    int done;
  } chk_t;

  chk_t tbl[$];

  multi_dir_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .hold       (hold),
    .cfg_we     (cfg_we),
    .cfg_phase  (cfg_phase),
    .cfg_data   (cfg_data),
    .light      (light),
    .countdown  (countdown),
    .active_dir (active_dir),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int l, input int c, input int d, input int done);
    chk({tag, " light"},      {28'd0, light},      l);
    chk({tag, " countdown"},  {24'd0, countdown},  c);
    chk({tag, " active_dir"}, {31'd0, active_dir}, d);
    chk({tag, " cycle_done"}, {31'd0, cycle_done}, done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    hold      = 1'b0;
    cfg_we    = 1'b0;
    cfg_phase = 2'b00;
    cfg_data  = 8'd0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Start-up, deferred config (write FWD=4 at cycle 20) and wrap-edge write (FWD=6 at 129).
    tbl.push_back(chk_t'{0,   4'b0010, 15, 0, 0});
    tbl.push_back(chk_t'{14,  4'b0010, 1,  0, 0});
    tbl.push_back(chk_t'{15,  4'b0011, 10, 0, 0});
    tbl.push_back(chk_t'{25,  4'b0001, 10, 0, 0});
    tbl.push_back(chk_t'{34,  4'b0001, 1,  0, 0});
    tbl.push_back(chk_t'{35,  4'b0000, 3,  0, 0});
    tbl.push_back(chk_t'{37,  4'b0000, 1,  0, 0});
    tbl.push_back(chk_t'{38,  4'b1000, 15, 1, 0});
    tbl.push_back(chk_t'{52,  4'b1000, 1,  1, 0});
    tbl.push_back(chk_t'{53,  4'b1100, 10, 1, 0});
    tbl.push_back(chk_t'{63,  4'b0100, 10, 1, 0});
    tbl.push_back(chk_t'{73,  4'b0000, 3,  1, 0});
    tbl.push_back(chk_t'{75,  4'b0000, 1,  1, 0});
    tbl.push_back(chk_t'{76,  4'b0010, 4,  0, 1});
    tbl.push_back(chk_t'{77,  4'b0010, 3,  0, 0});
    tbl.push_back(chk_t'{79,  4'b0010, 1,  0, 0});
    tbl.push_back(chk_t'{80,  4'b0011, 10, 0, 0});
    tbl.push_back(chk_t'{103, 4'b1000, 4,  1, 0});
    tbl.push_back(chk_t'{129, 4'b0000, 1,  1, 0});
    tbl.push_back(chk_t'{130, 4'b0010, 6,  0, 1});

    do_reset();
    chk_out("reset", 0, 0, 0, 0);

    enable = 1'b1;
    for (int cyc = 0; cyc <= 130; cyc++) begin
      step();
      foreach (tbl[i]) begin
        if (tbl[i].cyc == cyc) chk_out($sformatf("run c%0d", cyc), tbl[i].l, tbl[i].c, tbl[i].d, tbl[i].done);
      end
      if (cyc == 20 || cyc == 129) begin
        cfg_we    = 1'b1;
        cfg_phase = 2'b10;
        cfg_data  = (cyc == 20) ? 8'd4 : 8'd6;
      end else begin
        cfg_we = 1'b0;
      end
    end

    // Hold for 5 cycles at countdown 9: FWD stretches to 20 cycles.
    do_reset();
    enable = 1'b1;
    repeat (7) step();
    chk_out("pre-hold", 4'b0010, 9, 0, 0);
    hold = 1'b1;
    for (int h = 0; h < 5; h++) begin
      step();
      chk_out($sformatf("hold%0d", h), 4'b0010, 9, 0, 0);
    end
    hold = 1'b0;
    step();
    chk("post-hold countdown", {24'd0, countdown}, 8);
    repeat (7) step();
    chk_out("hold fwd end", 4'b0010, 1, 0, 0);
    step();
    chk_out("hold rgt", 4'b0011, 10, 0, 0);

    // Enable drop mid-RGT on approach 1, then restart.
    do_reset();
    enable = 1'b1;
    repeat (56) step();
    chk_out("dir1 rgt", 4'b1100, 8, 1, 0);
    enable = 1'b0;
    step();
    chk_out("en drop", 0, 0, 0, 0);
    enable = 1'b1;
    step();
    chk_out("re-enable", 4'b0010, 15, 0, 0);

    // Zero clamp on OFF duration written while idle.
    enable = 1'b0;
    step();
    cfg_we    = 1'b1;
    cfg_phase = 2'b00;
    cfg_data  = 8'd0;
    step();
    cfg_we = 1'b0;
    enable = 1'b1;
    repeat (36) step();
    chk_out("clamp clr", 4'b0000, 1, 0, 0);
    step();
    chk_out("clamp next", 4'b1000, 15, 1, 0);

    // Asynchronous reset between edges restores default durations.
    cfg_we    = 1'b1;
    cfg_phase = 2'b10;
    cfg_data  = 8'd4;
    step();
    cfg_we = 1'b0;
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    chk_out("async rst", 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    step();
    chk_out("post rst", 4'b0010, 15, 0, 0);
    repeat (35) step();
    chk_out("post rst clr", 4'b0000, 3, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
